inst_prefetch_buf: RTL and testbench

- Instruction prefetch queue sitting directly upstream of the FPU instruction synchronizer.
- Fetches 32-bit instruction words from instruction memory through a req/gnt/rvalid handshake and buffers them in a small FIFO.
- Presents the head word and its 6-bit opcode field to the synchronizer.
- Pops the head when the synchronizer asserts inst_fetch_en while not stalled by LSreq.

---
 rtl/fpu_fetch_pkg.sv | 17 +
 rtl/prefetch_fifo.sv | 56 +++++
 rtl/inst_prefetch_buf.sv | 160 ++++++++++++++++
 tb/tb_inst_prefetch_buf.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_fetch_pkg.sv
// Shared definitions for the FPU instruction prefetch path: fetch FSM
// states and the opcode field layout of a 32-bit instruction word.
package fpu_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } fetch_state_e;

  localparam int OPCODE_W = 6;
  localparam int OPC_MSB  = 31;
  localparam int OPC_LSB  = 26;

  localparam logic [OPCODE_W-1:0] NOP_OPCODE = 6'h00;

endpackage

// File: rtl/prefetch_fifo.sv
// Generic synchronous FIFO used to buffer prefetched {word, address} pairs.
// Pointers wrap naturally at DEPTH (power of two); count is one bit wider
// so full and empty are distinguishable. clear wins over push and pop.
module prefetch_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 64
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   clear,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           wdata,
  output logic [W-1:0]           rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          full;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // Storage write; contents need no reset because empty gates every read.
  always_ff @(posedge Clk) begin
    if (do_push && !clear) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/inst_prefetch_buf.sv
// Instruction prefetch queue in front of the FPU instruction synchronizer.
// Fetches words over req/gnt/rvalid, buffers them in prefetch_fifo and
// presents the head word, its opcode and its pc.
// Optional macro PREFETCH_PERF_EN adds the starve_cnt performance counter.
//
// Memory handshake: instr_req stays high with a stable instr_addr until a
// cycle with instr_gnt=1; that cycle transfers the request. Exactly one
// instr_rvalid follows later and carries that request's data; no new
// request is raised before it arrives. A request is only raised when the
// FIFO has room for the response (count + outstanding < DEPTH).
module inst_prefetch_buf
  import fpu_fetch_pkg::*;
#(
  parameter int                DEPTH     = 4,
  parameter int                ADDR_W    = 32,
  parameter int                INSTR_W   = 32,
  parameter logic [ADDR_W-1:0] BOOT_ADDR = '0
) (
  input  logic                   Clk,
  input  logic                   Reset,
  output logic                   instr_req,
  output logic [ADDR_W-1:0]      instr_addr,
  input  logic                   instr_gnt,
  input  logic                   instr_rvalid,
  input  logic [INSTR_W-1:0]     instr_rdata,
  input  logic                   flush,
  input  logic [ADDR_W-1:0]      flush_addr,
  input  logic                   inst_fetch_en,
  input  logic                   LSreq,
  output logic                   instr_valid,
  output logic [INSTR_W-1:0]     instr,
  output logic [OPCODE_W-1:0]    opcode,
  output logic [ADDR_W-1:0]      pc,
`ifdef PREFETCH_PERF_EN
  output logic [31:0]            starve_cnt,
`endif
  output fetch_state_e           dbg_state,
  output logic [$clog2(DEPTH):0] dbg_count
);

  localparam int                CNT_W   = $clog2(DEPTH) + 1;
  localparam logic [CNT_W:0]    DEPTH_C = (CNT_W+1)'(DEPTH);

  fetch_state_e               state;
  fetch_state_e               state_nxt;
  logic                       outstanding;
  logic                       drop;
  logic [ADDR_W-1:0]          fetch_addr;
  logic [ADDR_W-1:0]          inflight_addr;
  logic                       gnt_ok;
  logic                       push;
  logic                       pop;
  logic                       credit;
  logic                       credit_after;
  logic [CNT_W:0]             cnt_after;
  logic [CNT_W-1:0]           count;
  logic                       empty;
  logic                       head_valid;
  logic [INSTR_W+ADDR_W-1:0]  head;
  logic [INSTR_W-1:0]         head_word;

  assign gnt_ok     = (state == REQ) & instr_gnt;
  assign head_valid = ~empty;
  assign push       = instr_rvalid & outstanding & ~drop & ~flush;
  assign pop        = inst_fetch_en & ~LSreq & head_valid & ~flush;
  assign credit     = ({1'b0, count} + (CNT_W+1)'(outstanding)) < DEPTH_C;
  assign cnt_after  = {1'b0, count} + (CNT_W+1)'(push) - (CNT_W+1)'(pop);
  assign credit_after = cnt_after < DEPTH_C;

  prefetch_fifo #(
    .DEPTH (DEPTH),
    .W     (INSTR_W + ADDR_W)
  ) u_fifo (
    .Clk   (Clk),
    .Reset (Reset),
    .clear (flush),
    .push  (push),
    .pop   (pop),
    .wdata ({instr_rdata, inflight_addr}),
    .rdata (head),
    .count (count),
    .empty (empty)
  );

  // FSM state register.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state: request when there is room, wait for the single response.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (flush || credit) state_nxt = REQ;
      // A flush without gnt stays here; the address switches to flush_addr.
      REQ:  if (instr_gnt) state_nxt = WAIT;
      WAIT: begin
        if (instr_rvalid) begin
          if (flush || drop)     state_nxt = REQ;
          else if (credit_after) state_nxt = REQ;
          else                   state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs: the request is a pure function of state.
  always_comb begin
    instr_req  = (state == REQ);
    instr_addr = fetch_addr;
    dbg_state  = state;
  end

  // Fetch address, in-flight tracking and the drop flag for stale responses.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      fetch_addr    <= BOOT_ADDR;
      inflight_addr <= '0;
      outstanding   <= 1'b0;
      drop          <= 1'b0;
    end else begin
      if (flush)       fetch_addr <= flush_addr;
      else if (gnt_ok) fetch_addr <= fetch_addr + ADDR_W'(4);

      if (gnt_ok) inflight_addr <= fetch_addr;

      if (gnt_ok)            outstanding <= 1'b1;
      else if (instr_rvalid) outstanding <= 1'b0;

      // A response already in flight when flushing belongs to the old stream.
      if (flush && ((outstanding && !instr_rvalid) || gnt_ok)) drop <= 1'b1;
      else if (instr_rvalid && outstanding)                    drop <= 1'b0;
    end
  end

  // Head presentation; all fields read as zero while the queue is empty.
  always_comb begin
    head_word   = head[ADDR_W +: INSTR_W];
    instr_valid = head_valid;
    instr       = head_valid ? head_word : '0;
    opcode      = head_valid ? head_word[OPC_MSB:OPC_LSB] : NOP_OPCODE;
    pc          = head_valid ? head[ADDR_W-1:0] : '0;
    dbg_count   = count;
  end

`ifdef PREFETCH_PERF_EN
  // Count cycles where the synchronizer wanted an instruction and none was buffered.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset)
      starve_cnt <= '0;
    else if (flush)
      starve_cnt <= '0;
    else if (inst_fetch_en && !LSreq && !head_valid && (starve_cnt != 32'hFFFF_FFFF))
      starve_cnt <= starve_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_inst_prefetch_buf.sv
// Directed bench for inst_prefetch_buf with a small instruction-memory
// responder (gnt tied high, programmable gnt-to-rvalid delay).
module tb_inst_prefetch_buf;
  import fpu_fetch_pkg::*;

  localparam int DEPTH   = 4;
  localparam int ADDR_W  = 32;
  localparam int INSTR_W = 32;

  // ---------------- clock / reset ----------------
  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  logic                   instr_req;
  logic [ADDR_W-1:0]      instr_addr;
  logic                   instr_gnt;
  logic                   instr_rvalid = 1'b0;
  logic [INSTR_W-1:0]     instr_rdata  = '0;
  logic                   flush;
  logic [ADDR_W-1:0]      flush_addr;
  logic                   inst_fetch_en;
  logic                   LSreq;
  logic                   instr_valid;
  logic [INSTR_W-1:0]     instr;
  logic [OPCODE_W-1:0]    opcode;
  logic [ADDR_W-1:0]      pc;
  fetch_state_e           dbg_state;
  logic [$clog2(DEPTH):0] dbg_count;
`ifdef PREFETCH_PERF_EN
  logic [31:0]            starve_cnt;
`endif

  inst_prefetch_buf #(
    .DEPTH     (DEPTH),
    .ADDR_W    (ADDR_W),
    .INSTR_W   (INSTR_W),
    .BOOT_ADDR (32'h0000_0000)
  ) dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .instr_req     (instr_req),
    .instr_addr    (instr_addr),
    .instr_gnt     (instr_gnt),
    .instr_rvalid  (instr_rvalid),
    .instr_rdata   (instr_rdata),
    .flush         (flush),
    .flush_addr    (flush_addr),
    .inst_fetch_en (inst_fetch_en),
    .LSreq         (LSreq),
    .instr_valid   (instr_valid),
    .instr         (instr),
    .opcode        (opcode),
    .pc            (pc),
`ifdef PREFETCH_PERF_EN
    .starve_cnt    (starve_cnt),
`endif
    .dbg_state     (dbg_state),
    .dbg_count     (dbg_count)
  );

  // ---------------- scoreboard state ----------------
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] gnt_log[$];

  // Memory contents: opcode walks with the word index, low bits carry the address.
  function automatic logic [31:0] data_of(input logic [31:0] a);
    logic [5:0] op;
    op = a[7:2] + 6'h25;
    return {op, a[25:0]};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- memory responder ----------------
  int          mem_delay = 1;
  logic [31:0] bad_addr  = 32'hFFFF_FFF0;
  bit          pending   = 1'b0;
  int          rv_wait   = 0;
  logic [31:0] rv_addr   = '0;

  // Values driven at a negedge are seen by the DUT at the following posedge;
  // a req&gnt visible now therefore means a grant at the next posedge.
  always @(negedge Clk) begin
    instr_rvalid = 1'b0;
    instr_rdata  = '0;
    if (!Reset) begin
      pending = 1'b0;
    end else begin
      if (pending) begin
        if (rv_wait <= 1) begin
          instr_rvalid = 1'b1;
          instr_rdata  = (rv_addr == bad_addr) ? 32'hDEAD_BEEF : data_of(rv_addr);
          pending      = 1'b0;
        end else begin
          rv_wait--;
        end
      end
      if (instr_req && instr_gnt && !pending) begin
        pending = 1'b1;
        rv_addr = instr_addr;
        rv_wait = mem_delay;
        gnt_log.push_back(instr_addr);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Drive one cycle of inst_fetch_en; a pop taking place is checked against exp_q.
  task automatic drive_pop(input bit en);
    logic [31:0] e;
    inst_fetch_en = en;
    if (en && instr_valid && !LSreq && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("pop_pc", 64'(pc), 64'(e));
      check("pop_instr", 64'(instr), 64'(data_of(e)));
    end
    @(negedge Clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    Reset = 1'b0; instr_gnt = 1'b1; flush = 1'b0; flush_addr = '0;
    inst_fetch_en = 1'b0; LSreq = 1'b0;
    repeat (2) @(negedge Clk);

    // Reset state
    check("rst_valid", 64'(instr_valid), 64'd0);
    check("rst_instr", 64'(instr), 64'd0);
    check("rst_opcode", 64'(opcode), 64'd0);
    check("rst_pc", 64'(pc), 64'd0);
    check("rst_req", 64'(instr_req), 64'd0);
    check("rst_addr", 64'(instr_addr), 64'd0);
    check("rst_state", 64'(dbg_state), 64'(IDLE));

    // Fill from boot address, one word per two cycles
    Reset = 1'b1;
    @(negedge Clk);
    check("first_req", 64'(instr_req), 64'd1);
    check("first_addr", 64'(instr_addr), 64'h0);
    @(negedge Clk);
    check("no_bypass", 64'(instr_valid), 64'd0);
    @(negedge Clk);
    check("first_valid", 64'(instr_valid), 64'd1);
    check("first_pc", 64'(pc), 64'h0);
    check("first_instr", 64'(instr), 64'h9400_0000);
    check("first_opcode", 64'(opcode), 64'h25);
    repeat (6) @(negedge Clk);
    check("full_count", 64'(dbg_count), 64'd4);
    check("full_req", 64'(instr_req), 64'd0);
    check("full_state", 64'(dbg_state), 64'(IDLE));
    check("gnt_cnt", 64'(gnt_log.size()), 64'd4);
    for (int i = 0; i < 4 && i < gnt_log.size(); i++)
      check("gnt_addr", 64'(gnt_log[i]), 64'(4 * i));

    // Stall: LSreq blocks the pop while fetch_en is held
    inst_fetch_en = 1'b1; LSreq = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      check("stall_opcode", 64'(opcode), 64'h25);
      check("stall_pc", 64'(pc), 64'h0);
      check("stall_req", 64'(instr_req), 64'd0);
    end

    // Single pop frees one slot -> one new request
    LSreq = 1'b0;
    @(negedge Clk);
    inst_fetch_en = 1'b0;
    check("pop1_pc", 64'(pc), 64'h4);
    check("pop1_opcode", 64'(opcode), 64'h26);
    check("pop1_instr", 64'(instr), 64'h9800_0004);
    check("pop1_count", 64'(dbg_count), 64'd3);
    @(negedge Clk);
    check("refill_req", 64'(instr_req), 64'd1);
    check("refill_addr", 64'(instr_addr), 64'h10);
    repeat (2) @(negedge Clk);
    check("refill_count", 64'(dbg_count), 64'd4);
    check("refill_idle", 64'(instr_req), 64'd0);

    // Flush while waiting: the in-flight 0xDEADBEEF response must be discarded
    mem_delay = 3; bad_addr = 32'h14;
    inst_fetch_en = 1'b1;
    @(negedge Clk);
    inst_fetch_en = 1'b0;
    @(negedge Clk);
    check("pre_flush_addr", 64'(instr_addr), 64'h14);
    @(negedge Clk);
    check("pre_flush_state", 64'(dbg_state), 64'(WAIT));
    flush = 1'b1; flush_addr = 32'h100;
    @(negedge Clk);
    flush = 1'b0; mem_delay = 1;
    check("flush_valid", 64'(instr_valid), 64'd0);
    check("flush_count", 64'(dbg_count), 64'd0);
    check("flush_instr", 64'(instr), 64'd0);
    check("flush_pc", 64'(pc), 64'd0);
    check("flush_state", 64'(dbg_state), 64'(WAIT));
    repeat (2) @(negedge Clk);
    check("drop_count", 64'(dbg_count), 64'd0);
    check("restart_req", 64'(instr_req), 64'd1);
    check("restart_addr", 64'(instr_addr), 64'h100);
    repeat (2) @(negedge Clk);
    check("restart_valid", 64'(instr_valid), 64'd1);
    check("restart_pc", 64'(pc), 64'h100);
    check("restart_instr", 64'(instr), 64'h9400_0100);
    repeat (8) @(negedge Clk);
    check("refull_count", 64'(dbg_count), 64'd4);

    // Order across pointer wrap, with a push+pop at count 2
    for (int i = 0; i < 8; i++) exp_q.push_back(32'h100 + 32'(4 * i));
    drive_pop(1'b1);
    drive_pop(1'b1);
    drive_pop(1'b0);
    drive_pop(1'b1);
    check("pushpop_count", 64'(dbg_count), 64'd2);
    for (int i = 0; i < 80 && exp_q.size() > 0; i++) drive_pop(1'b1);
    drive_pop(1'b0);
    check("wrap_drained", 64'(exp_q.size()), 64'd0);

    // Asynchronous reset in the middle of traffic
    Reset = 1'b0;
    #1;
    check("async_req", 64'(instr_req), 64'd0);
    check("async_valid", 64'(instr_valid), 64'd0);
    check("async_count", 64'(dbg_count), 64'd0);
    check("async_addr", 64'(instr_addr), 64'h0);
    check("async_state", 64'(dbg_state), 64'(IDLE));
    repeat (2) @(negedge Clk);

`ifdef PREFETCH_PERF_EN
    // Starvation counter: rvalid 5 cycles after reset release
    mem_delay = 3;
    Reset = 1'b1; inst_fetch_en = 1'b1;
    repeat (5) @(negedge Clk);
    inst_fetch_en = 1'b0;
    check("starve_valid", 64'(instr_valid), 64'd1);
    check("starve_cnt", 64'(starve_cnt), 64'd5);
    flush = 1'b1; flush_addr = 32'h200;
    @(negedge Clk);
    flush = 1'b0;
    check("starve_flush", 64'(starve_cnt), 64'd0);
    repeat (4) @(negedge Clk);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
